// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: IDLE -> ADDR -> WAIT -> ISSUE, one retired word per loop, 3 cycles minimum.
// Memory stalls are tolerated for WAIT_MAX edges before a sticky FAULT. IR is held until EXEC_DONE.
module fetch_sequencer #(
  parameter int                     BITS        = 16,
  parameter int                     OPCODE_BITS = 4,
  parameter logic [OPCODE_BITS-1:0] HALT_OPCODE = 4'hF,
  parameter int                     WAIT_MAX    = 8
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            START,
  input  logic [BITS-1:0] PC_VALUE,
  input  logic            MEM_READY,
  input  logic [BITS-1:0] MEM_DATA,
  input  logic            EXEC_DONE,
  output logic [BITS-1:0] MEM_ADDR,
  output logic            MEM_READ,
  output logic            PC_INCREMENT,
  output logic [BITS-1:0] IR_OUT,
  output logic            IR_VALID,
  output logic            BUSY,
  output logic            FAULT,
  output logic [BITS-1:0] FETCH_COUNT
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          wait_cnt_q;
  logic [BITS-1:0]        mem_addr_q;
  logic                   mem_read_q;
  logic                   pc_inc_q;
  logic [BITS-1:0]        ir_q;
  logic                   ir_valid_q;
  logic                   busy_q;
  logic                   fault_q;
  logic [BITS-1:0]        fetch_cnt_q;
  logic [OPCODE_BITS-1:0] opcode;

  assign opcode = ir_q[BITS-1 -: OPCODE_BITS];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      pc_inc_q    <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
          end
        end
        // PC is sampled here rather than at retire so an execute-stage LOAD lands first.
        S_ADDR: begin
          mem_addr_q <= PC_VALUE;
          mem_read_q <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (MEM_READY) begin
            ir_q       <= MEM_DATA;
            ir_valid_q <= 1'b1;
            mem_read_q <= 1'b0;
            pc_inc_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
            if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
              mem_read_q <= 1'b0;
              fault_q    <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_FAULT;
            end
          end
        end
        S_ISSUE: begin
          pc_inc_q <= 1'b0;
          if (EXEC_DONE) begin
            ir_valid_q  <= 1'b0;
            fetch_cnt_q <= fetch_cnt_q + BITS'(1);
            if (opcode == HALT_OPCODE) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_ADDR;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign MEM_ADDR     = mem_addr_q;
  assign MEM_READ     = mem_read_q;
  assign PC_INCREMENT = pc_inc_q;
  assign IR_OUT       = ir_q;
  assign IR_VALID     = ir_valid_q;
  assign BUSY         = busy_q;
  assign FAULT        = fault_q;
  assign FETCH_COUNT  = fetch_cnt_q;

endmodule
